// File: rtl/corr_readout_ctrl.sv
// Read-side controller for the correlator MAC RAM bank: fetches every bin and streams it as
// a header byte followed by 4 bytes per bin (LSB first), optionally clearing the bank afterwards.
module corr_readout_ctrl #(
    parameter int         NBINS   = 256,
    parameter int         AW      = 8,
    parameter int         RD_LAT  = 3,
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         CLR_LEN = 258
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clr_after,
    output logic          busy,
    output logic          done,
    output logic          read,
    output logic [AW-1:0] rAddr,
    input  logic [31:0]   rData,
    output logic          clr,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int CW_W  = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;

    localparam logic [AW:0]      LAST_BIN = (AW+1)'(NBINS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [CW_W-1:0]  CW_LAST  = CW_W'(CLR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_SEND  = 3'd3,
        S_CLR   = 3'd4,
        S_CWAIT = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t           state_r, state_s;
    logic [AW:0]      bin_r, bin_s, bin_inc_s;
    logic [LAT_W-1:0] lat_cnt_r, lat_cnt_s;
    logic [CW_W-1:0]  cw_cnt_r, cw_cnt_s;
    logic [1:0]       byte_idx_r, byte_idx_s;
    logic [31:0]      word_r, word_s;
    logic             clr_after_r, clr_after_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             read_r, read_s;
    logic [AW-1:0]    raddr_r, raddr_s;
    logic             clr_r, clr_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             tx_valid_r, tx_valid_s;
    logic             tx_hs_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            2'd3:    byte_sel = w[31:24];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign bin_inc_s = bin_r + (AW+1)'(1);
    assign tx_hs_s   = tx_valid_r & tx_ready;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        bin_s       = bin_r;
        lat_cnt_s   = lat_cnt_r;
        cw_cnt_s    = cw_cnt_r;
        byte_idx_s  = byte_idx_r;
        word_s      = word_r;
        clr_after_s = clr_after_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        read_s      = read_r;
        raddr_s     = raddr_r;
        clr_s       = 1'b0;
        tx_data_s   = tx_data_r;
        tx_valid_s  = tx_valid_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    clr_after_s = clr_after;
                    bin_s       = '0;
                    busy_s      = 1'b1;
                    tx_data_s   = HDR;
                    tx_valid_s  = 1'b1;
                    state_s     = S_HDR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HDR: begin
                if (tx_hs_s) begin
                    tx_valid_s = 1'b0;
                    read_s     = 1'b1;
                    raddr_s    = bin_r[AW-1:0];
                    lat_cnt_s  = '0;
                    state_s    = S_FETCH;
                end else begin
                    state_s = S_HDR;
                end
            end
            S_FETCH: begin
                if (lat_cnt_r == LAT_LAST) begin
                    word_s     = rData;
                    byte_idx_s = 2'd0;
                    tx_data_s  = rData[7:0];
                    tx_valid_s = 1'b1;
                    state_s    = S_SEND;
                end else begin
                    lat_cnt_s = lat_cnt_r + LAT_W'(1);
                end
            end
            S_SEND: begin
                if (!tx_hs_s) begin
                    state_s = S_SEND;
                end else if (byte_idx_r != 2'd3) begin
                    byte_idx_s = byte_idx_r + 2'd1;
                    tx_data_s  = byte_sel(word_r, byte_idx_r + 2'd1);
                end else if (bin_r == LAST_BIN) begin
                    // Frame complete: drop read so the bank leaves its read state.
                    tx_valid_s = 1'b0;
                    read_s     = 1'b0;
                    if (clr_after_r) begin
                        state_s = S_CLR;
                    end else begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = S_FIN;
                    end
                end else begin
                    tx_valid_s = 1'b0;
                    bin_s      = bin_inc_s;
                    raddr_s    = bin_inc_s[AW-1:0];
                    lat_cnt_s  = '0;
                    state_s    = S_FETCH;
                end
            end
            S_CLR: begin
                clr_s    = 1'b1;
                cw_cnt_s = '0;
                state_s  = S_CWAIT;
            end
            S_CWAIT: begin
                if (cw_cnt_r == CW_LAST) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_FIN;
                end else begin
                    cw_cnt_s = cw_cnt_r + CW_W'(1);
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s    = S_IDLE;
                busy_s     = 1'b0;
                read_s     = 1'b0;
                tx_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            bin_r       <= '0;
            lat_cnt_r   <= '0;
            cw_cnt_r    <= '0;
            byte_idx_r  <= 2'd0;
            word_r      <= 32'd0;
            clr_after_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            read_r      <= 1'b0;
            raddr_r     <= '0;
            clr_r       <= 1'b0;
            tx_data_r   <= 8'd0;
            tx_valid_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            bin_r       <= bin_s;
            lat_cnt_r   <= lat_cnt_s;
            cw_cnt_r    <= cw_cnt_s;
            byte_idx_r  <= byte_idx_s;
            word_r      <= word_s;
            clr_after_r <= clr_after_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            read_r      <= read_s;
            raddr_r     <= raddr_s;
            clr_r       <= clr_s;
            tx_data_r   <= tx_data_s;
            tx_valid_r  <= tx_valid_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign read     = read_r;
    assign rAddr    = raddr_r;
    assign clr      = clr_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;

endmodule

// File: tb/tb_corr_readout_ctrl.sv
// Directed bench for corr_readout_ctrl: a small bank model with RD_LAT-accurate read data,
// a byte/event monitor, and one task per scenario with hand-derived expected bytes.
module tb_corr_readout_ctrl;

    localparam int NB      = 256;
    localparam int CLR_LEN = 258;
    localparam int FRAME   = 1 + 4 * NB;

    logic        clk = 1'b0;
    logic        rst_n, start, clr_after;
    logic        busy, done, read, clr, tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rAddr, tx_data;
    logic [31:0] rData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    corr_readout_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_after(clr_after),
        .busy(busy), .done(done), .read(read), .rAddr(rAddr), .rData(rData),
        .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // Bank model: preloaded pattern, cleared once a clr is seen after clr_base was taken.
    int mode = 0;
    int clr_base = 0;
    int clr_cnt = 0;
    logic [31:0] p1;

    function automatic logic [31:0] bank_word(input logic [7:0] a);
        if (clr_cnt != clr_base) return 32'd0;
        if (mode == 1 && a == 8'hFF) return 32'hFFFF_FFFF;
        return ({24'd0, a} * 32'h0000_0101) + 32'h0100_0000;
    endfunction

    // Two register stages: data is valid on the third cycle after rAddr is driven.
    always @(posedge clk) begin
        p1    <= bank_word(rAddr);
        rData <= p1;
    end

    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: logs accepted bytes and counts events/violations sampled mid-cycle.
    logic [7:0] byte_log[$];
    int   cyc = 0, last_hs_cyc = 0, clr_cyc = 0, done_cyc = 0;
    int   done_cnt = 0, stall_viol = 0, clr_read_viol = 0, read_rise = 0;
    logic prev_stall = 1'b0, prev_read = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) begin
            byte_log.push_back(tx_data);
            last_hs_cyc <= cyc;
        end
        if (prev_stall && rst_n && (!tx_valid || tx_data !== prev_data)) stall_viol <= stall_viol + 1;
        prev_stall <= rst_n && tx_valid && !tx_ready;
        prev_data  <= tx_data;
        if (clr) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
            if (read) clr_read_viol <= clr_read_viol + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (read && !prev_read) read_rise <= read_rise + 1;
        prev_read <= read;
    end

    logic [7:0] exp_q[$];

    task automatic build_expected(input int m, input bit cleared);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NB; k++) begin
            if (cleared) begin
                repeat (4) exp_q.push_back(8'h00);
            end else if (m == 1 && k == NB - 1) begin
                repeat (4) exp_q.push_back(8'hFF);
            end else begin
                exp_q.push_back(8'(k));
                exp_q.push_back(8'(k));
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h01);
            end
        end
    endtask

    task automatic pulse_start(input logic ca);
        @(posedge clk); #1;
        start = 1'b1; clr_after = ca;
        @(posedge clk); #1;
        start = 1'b0; clr_after = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, read, clr, tx_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, read, clr, tx_valid});
        end
        checks++;
        if ({rAddr, tx_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got rAddr=%h tx_data=%h expected 00/00", rAddr, tx_data);
        end
    endtask

    task automatic test_basic_frame;
        int base, d0, c0, r0;
        bit ok;
        mode = 0; clr_base = clr_cnt;
        build_expected(0, 1'b0);
        base = byte_log.size(); d0 = done_cnt; c0 = clr_cnt; r0 = read_rise;
        pulse_start(1'b0);
        checks++;
        if (!busy) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done expected done"); end
        repeat (5) @(negedge clk); #1;
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL basic_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        for (int i = 0; i < FRAME && base + i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, byte_log[base+i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (clr_cnt - c0 !== 0) begin errors++; $display("FAIL basic_no_clr: got %0d expected 0", clr_cnt - c0); end
        checks++;
        if (read_rise - r0 !== 1) begin errors++; $display("FAIL basic_read_cont: got %0d rises expected 1", read_rise - r0); end
        checks++;
        if (done_cyc - last_hs_cyc !== 1) begin
            errors++; $display("FAIL basic_done_lat: got %0d expected 1", done_cyc - last_hs_cyc);
        end
        checks++;
        if ({busy, read} !== 2'b00) begin errors++; $display("FAIL basic_idle: got %b expected 00", {busy, read}); end
    endtask

    task automatic test_random_ready;
        int base, s0;
        bit ok;
        build_expected(0, 1'b0);
        base = byte_log.size(); s0 = stall_viol;
        rnd_ready = 1'b1;
        pulse_start(1'b0);
        wait_done(ok);
        rnd_ready = 1'b0;
        repeat (5) @(negedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL rnd_done_timeout: got no done expected done"); end
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL rnd_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        for (int i = 0; i < FRAME && base + i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_byte[%0d]: got %h expected %h", i, byte_log[base+i], exp_q[i]);
            end
        end
        checks++;
        if (stall_viol - s0 !== 0) begin errors++; $display("FAIL rnd_stall_stable: got %0d violations expected 0", stall_viol - s0); end
    endtask

    task automatic test_clear;
        int base, c0, d0;
        bit ok;
        clr_base = clr_cnt;
        build_expected(0, 1'b0);
        base = byte_log.size(); c0 = clr_cnt; d0 = done_cnt;
        pulse_start(1'b1);
        wait_done(ok);
        repeat (5) @(negedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL clr_done_timeout: got no done expected done"); end
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL clr_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        checks++;
        if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL clr_pulses: got %0d expected 1", clr_cnt - c0); end
        checks++;
        if (clr_cyc - last_hs_cyc !== 2) begin errors++; $display("FAIL clr_lat: got %0d expected 2", clr_cyc - last_hs_cyc); end
        checks++;
        if (done_cyc - last_hs_cyc !== CLR_LEN + 2) begin
            errors++; $display("FAIL clr_done_lat: got %0d expected %0d", done_cyc - last_hs_cyc, CLR_LEN + 2);
        end
        checks++;
        if (clr_read_viol !== 0) begin errors++; $display("FAIL clr_while_read: got %0d expected 0", clr_read_viol); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL clr_done_cnt: got %0d expected 1", done_cnt - d0); end
        // Second readout of the now-cleared bank.
        build_expected(0, 1'b1);
        base = byte_log.size();
        pulse_start(1'b0);
        wait_done(ok);
        repeat (5) @(negedge clk); #1;
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL clr2_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        for (int i = 0; i < FRAME && base + i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL clr2_byte[%0d]: got %h expected %h", i, byte_log[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int base, d0;
        bit ok, hit;
        clr_base = clr_cnt; mode = 0;
        base = byte_log.size(); d0 = done_cnt;
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (busy && rAddr == 8'd10) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL ign_bin10_timeout: got no bin 10 expected bin 10"); end
        pulse_start(1'b1);
        wait_done(ok);
        // Start during the done cycle must also be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL ign_done_timeout: got no done expected done"); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL ign_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_fin_start: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int base, c0;
        bit ok, hit;
        build_expected(0, 1'b0);
        base = byte_log.size(); c0 = clr_cnt;
        pulse_start(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (byte_log.size() - base == 1 + 4 * 100 + 3) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || rAddr !== 8'd100) begin
            errors++; $display("FAIL rst_reach: got rAddr=%h expected 64", rAddr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({read, tx_valid, busy, clr} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_outs: got %b expected 0000", {read, tx_valid, busy, clr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk); #1;
        checks++;
        if (clr_cnt - c0 !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_resume: got clr=%0d busy=%b expected 0/0", clr_cnt - c0, busy);
        end
        base = byte_log.size();
        pulse_start(1'b0);
        wait_done(ok);
        repeat (5) @(negedge clk); #1;
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL rst_new_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        for (int i = 0; i < FRAME && base + i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL rst_new_byte[%0d]: got %h expected %h", i, byte_log[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_last_bin;
        int base;
        bit ok;
        mode = 1; clr_base = clr_cnt;
        build_expected(1, 1'b0);
        base = byte_log.size();
        pulse_start(1'b0);
        wait_done(ok);
        repeat (20) @(negedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL last_done_timeout: got no done expected done"); end
        checks++;
        if (byte_log.size() - base !== FRAME) begin
            errors++; $display("FAIL last_len: got %0d expected %0d", byte_log.size() - base, FRAME);
        end
        for (int i = 0; i < FRAME && base + i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[base+i] !== exp_q[i]) begin
                errors++; $display("FAIL last_byte[%0d]: got %h expected %h", i, byte_log[base+i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clr_after = 1'b0;
        repeat (3) @(posedge clk); #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_basic_frame();
        test_random_ready();
        test_clear();
        test_start_ignored();
        test_reset_mid();
        test_last_bin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
